alu_share_arbiter: RTL and testbench

- Shares one registered WIDTH-bit logic/arithmetic unit (AND/OR/XOR/ADD) between two requesters in the processor datapath.
- Round-robin arbitration, valid/ready handshake on the request side, and a held response with requester ID.
- Sequences each operation through a small FSM: IDLE -> EXEC -> RESP.
- Only one operation is in flight at a time; this is the serialising controller in front of the shared ALU.

---
 rtl/alu_share_arbiter.sv | 121 ++++++++++++
 tb/tb_alu_share_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one registered AND/OR/XOR/ADD unit between two requesters.
// One operation in flight at a time, sequenced IDLE -> EXEC (LAT cycles) -> RESP.
module alu_share_arbiter #(
   parameter int WIDTH = 8,
   parameter int LAT   = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [1:0]       req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [1:0]       req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_carry,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
   typedef enum logic [1:0] {OP_AND, OP_OR, OP_XOR, OP_ADD} op_t;

   localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

   state_t           state, state_next;
   op_t              op_code;
   logic [WIDTH-1:0] op_a, op_b;
   logic [3:0]       cnt;
   logic             last_grant;
   logic             exec_done;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] result;
   logic             carry;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_next = state;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      exec_done  = 1'b0;
      case (state)
         IDLE: begin
            // The requester that did not win last time takes a tie.
            req0_ready = req0_valid && (!req1_valid || last_grant);
            req1_ready = req1_valid && (!req0_valid || !last_grant);
            if (req0_ready || req1_ready) state_next = EXEC;
         end
         EXEC: begin
            if (cnt == 4'd0) begin
               exec_done  = 1'b1;
               state_next = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign sum = {1'b0, op_a} + {1'b0, op_b};

   always_comb begin
      result = '0;
      carry  = 1'b0;
      case (op_code)
         OP_AND: result = op_a & op_b;
         OP_OR:  result = op_a | op_b;
         OP_XOR: result = op_a ^ op_b;
         OP_ADD: {carry, result} = sum;
         default: result = '0;
      endcase
   end

   // NOTE: operand and response registers are reset too, since their reset values are architecturally visible.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= 1'b1;
         cnt        <= 4'd0;
         op_code    <= OP_AND;
         op_a       <= '0;
         op_b       <= '0;
         rsp_valid  <= 1'b0;
         rsp_id     <= 1'b0;
         rsp_data   <= '0;
         rsp_carry  <= 1'b0;
      end else begin
         if (req0_ready || req1_ready) begin
            op_code    <= req1_ready ? op_t'(req1_op) : op_t'(req0_op);
            op_a       <= req1_ready ? req1_a : req0_a;
            op_b       <= req1_ready ? req1_b : req0_b;
            rsp_id     <= req1_ready;
            last_grant <= req1_ready;
            cnt        <= CNT_LOAD;
         end
         if (state == EXEC && cnt != 4'd0) cnt <= cnt - 4'd1;
         if (exec_done) begin
            rsp_data  <= result;
            rsp_carry <= carry;
            rsp_valid <= 1'b1;
         end
         if (state == RESP && rsp_ready) rsp_valid <= 1'b0;
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench: stimulus pushes expected responses, monitors pop them on each response handshake.
// A LAT=1 instance covers most behaviour; a LAT=4 instance covers the longer execute latency.
module tb_alu_share_arbiter;

   typedef struct {
      logic       id;
      logic [7:0] data;
      logic       carry;
   } rsp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic       req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
   logic [1:0] req0_op = 0, req1_op = 0;
   logic [7:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
   logic       rsp_valid, rsp_ready = 1, rsp_id, rsp_carry, busy;
   logic [7:0] rsp_data;

   logic       l4_req0_valid = 0, l4_req0_ready, l4_req1_ready;
   logic [1:0] l4_req0_op = 0;
   logic [7:0] l4_req0_a = 0, l4_req0_b = 0;
   logic       l4_req1_valid = 0;
   logic [1:0] l4_req1_op = 0;
   logic [7:0] l4_req1_a = 0, l4_req1_b = 0;
   logic       l4_rsp_valid, l4_rsp_ready = 1, l4_rsp_id, l4_rsp_carry, l4_busy;
   logic [7:0] l4_rsp_data;

   alu_share_arbiter #(.WIDTH(8), .LAT(1)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
      .rsp_carry(rsp_carry), .busy(busy)
   );

   alu_share_arbiter #(.WIDTH(8), .LAT(4)) dut_l4 (
      .clk(clk), .rst(rst),
      .req0_valid(l4_req0_valid), .req0_ready(l4_req0_ready), .req0_op(l4_req0_op), .req0_a(l4_req0_a), .req0_b(l4_req0_b),
      .req1_valid(l4_req1_valid), .req1_ready(l4_req1_ready), .req1_op(l4_req1_op), .req1_a(l4_req1_a), .req1_b(l4_req1_b),
      .rsp_valid(l4_rsp_valid), .rsp_ready(l4_rsp_ready), .rsp_id(l4_rsp_id), .rsp_data(l4_rsp_data),
      .rsp_carry(l4_rsp_carry), .busy(l4_busy)
   );

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   rsp_t exp_q[$];
   rsp_t exp4_q[$];
   bit   both_ready_seen = 0;
   bit   ready_busy_seen = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst) begin
         if (req0_ready && req1_ready) both_ready_seen = 1;
         if ((req0_ready || req1_ready) && busy) ready_busy_seen = 1;
      end
   end

   always @(negedge clk) begin : mon_l1
      rsp_t e;
      if (!rst && rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) check("unexpected_rsp", 1, 0);
         else begin
            e = exp_q.pop_front();
            check("rsp_id", rsp_id, e.id);
            check("rsp_data", rsp_data, e.data);
            check("rsp_carry", rsp_carry, e.carry);
         end
      end
   end

   always @(negedge clk) begin : mon_l4
      rsp_t e;
      if (!rst && l4_rsp_valid && l4_rsp_ready) begin
         if (exp4_q.size() == 0) check("l4_unexpected_rsp", 1, 0);
         else begin
            e = exp4_q.pop_front();
            check("l4_rsp_id", l4_rsp_id, e.id);
            check("l4_rsp_data", l4_rsp_data, e.data);
            check("l4_rsp_carry", l4_rsp_carry, e.carry);
         end
      end
   end

   function automatic logic cond(input int which);
      case (which)
         0: return req0_ready;
         1: return req1_ready;
         2: return req0_ready || req1_ready;
         3: return rsp_valid;
         4: return l4_req0_ready;
         default: return l4_rsp_valid;
      endcase
   endfunction

   // Waits (bounded) for a condition sampled on the falling edge.
   task automatic wait_cond(input int which, output bit ok);
      ok = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (cond(which)) begin
            ok = 1;
            return;
         end
      end
      total++;
      bad++;
      $display("FAIL wait_timeout: cond=%0d got=0 need=1", which);
   endtask

   // Issues one op on the LAT=1 instance with rsp_ready high and checks the response latency.
   task automatic send(input int n, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] data, input logic carry);
      bit ok;
      int acc;
      rsp_t e;
      e.id = n[0]; e.data = data; e.carry = carry;
      exp_q.push_back(e);
      if (n == 0) begin req0_valid = 1; req0_op = op; req0_a = a; req0_b = b; end
      else        begin req1_valid = 1; req1_op = op; req1_a = a; req1_b = b; end
      wait_cond(n, ok);
      acc = cyc;
      @(posedge clk); #1;
      req0_valid = 0; req1_valid = 0;
      req0_a = 8'h5A; req0_b = 8'hC3; req1_a = 8'h5A; req1_b = 8'hC3;
      check("ready_drops_after_accept", {req0_ready, req1_ready, busy}, 3'b001);
      wait_cond(3, ok);
      check("latency", cyc - acc, 2);
      @(posedge clk); #1;
   endtask

   initial begin
      bit   ok;
      int   acc;
      rsp_t e;

      repeat (3) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      check("reset_state", {rsp_valid, rsp_id, rsp_carry, busy, rsp_data}, 12'h000);
      check("l4_reset_state", {l4_rsp_valid, l4_busy, l4_rsp_data}, 10'h000);
      @(posedge clk); #1;

      // Requester 0 AND, twice.
      send(0, 2'b00, 8'hB8, 8'h09, 8'h08, 1'b0);
      send(0, 2'b00, 8'hA8, 8'h09, 8'h08, 1'b0);

      // Requester 1 alone: OR, XOR, ADD with wrap.
      send(1, 2'b01, 8'hB8, 8'h09, 8'hB9, 1'b0);
      send(1, 2'b10, 8'hB8, 8'h09, 8'hB1, 1'b0);
      send(1, 2'b11, 8'hFF, 8'h01, 8'h00, 1'b1);

      // Both requesters valid continuously: grants must alternate 0,1,0,1.
      req0_valid = 1; req0_op = 2'b00; req0_a = 8'hB8; req0_b = 8'h09;
      req1_valid = 1; req1_op = 2'b11; req1_a = 8'h10; req1_b = 8'h20;
      for (int i = 0; i < 4; i++) begin
         wait_cond(2, ok);
         check("grant_order", {31'd0, req1_ready}, i % 2);
         if (i % 2 == 0) begin e.id = 0; e.data = 8'h08; e.carry = 0; end
         else            begin e.id = 1; e.data = 8'h30; e.carry = 0; end
         exp_q.push_back(e);
         wait_cond(3, ok);
         if (i == 3) begin
            req0_valid = 0; req1_valid = 0;
         end
         @(posedge clk); #1;
      end

      // Backpressure: response must hold while rsp_ready is low.
      rsp_ready = 0;
      e.id = 0; e.data = 8'hFF; e.carry = 0;
      exp_q.push_back(e);
      req0_valid = 1; req0_op = 2'b10; req0_a = 8'h0F; req0_b = 8'hF0;
      wait_cond(0, ok);
      @(posedge clk); #1;
      req0_valid = 0;
      e.id = 1; e.data = 8'h0C; e.carry = 0;
      exp_q.push_back(e);
      req1_valid = 1; req1_op = 2'b00; req1_a = 8'h3C; req1_b = 8'h0F;
      wait_cond(3, ok);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold_under_backpressure",
               {rsp_valid, rsp_id, rsp_carry, busy, req0_ready, req1_ready, rsp_data}, {6'b100100, 8'hFF});
      end
      @(posedge clk); #1;
      rsp_ready = 1;
      @(posedge clk); #1;
      check("release_valid_drop", {rsp_valid, busy}, 2'b00);
      check("data_retained", rsp_data, 8'hFF);
      check("accept_after_release", {req0_ready, req1_ready}, 2'b01);
      @(posedge clk); #1;
      req1_valid = 0;
      wait_cond(3, ok);
      @(posedge clk); #1;

      // LAT=4 instance: ADD 80+80.
      e.id = 0; e.data = 8'h00; e.carry = 1;
      exp4_q.push_back(e);
      l4_req0_valid = 1; l4_req0_op = 2'b11; l4_req0_a = 8'h80; l4_req0_b = 8'h80;
      wait_cond(4, ok);
      acc = cyc;
      @(posedge clk); #1;
      l4_req0_valid = 0;
      wait_cond(5, ok);
      check("l4_latency", cyc - acc, 5);
      @(posedge clk); #1;

      // Reset during EXEC after a req1 grant: op discarded, req0 wins the next tie.
      req1_valid = 1; req1_op = 2'b11; req1_a = 8'h01; req1_b = 8'h02;
      wait_cond(1, ok);
      @(posedge clk); #1;
      req1_valid = 0;
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      check("reset_mid_exec",
            {rsp_valid, rsp_id, rsp_carry, busy, rsp_data}, 12'h000);
      e.id = 0; e.data = 8'hB1; e.carry = 0;
      exp_q.push_back(e);
      req0_valid = 1; req0_op = 2'b10; req0_a = 8'hB8; req0_b = 8'h09;
      req1_valid = 1; req1_op = 2'b01; req1_a = 8'h01; req1_b = 8'h02;
      @(negedge clk);
      check("grant_after_reset", {req0_ready, req1_ready}, 2'b10);
      @(posedge clk); #1;
      req0_valid = 0; req1_valid = 0;
      wait_cond(3, ok);
      @(posedge clk); #1;
      repeat (2) @(posedge clk);

      check("ready_never_both", {31'd0, both_ready_seen}, 0);
      check("ready_only_idle", {31'd0, ready_busy_seen}, 0);
      check("scoreboard_drained", exp_q.size(), 0);
      check("l4_scoreboard_drained", exp4_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
